btle_rx_iq_frontend: RTL and testbench



---
 rtl/btle_rx_iq_frontend_pkg.sv | 42 ++++
 rtl/btle_rx_iq_frontend_if.sv | 30 +++
 rtl/btle_rx_iq_frontend_dc.sv | 51 +++++
 rtl/btle_rx_iq_frontend.sv | 136 +++++++++++++
 tb/tb_btle_rx_iq_frontend.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/btle_rx_iq_frontend_pkg.sv
// btle_rx_fe_pkg: shared types and width helpers for the BTLE RX I/Q frontend.
// Every width-derived constant comes from a helper function, so the top and the
// DC tracker compute the same value from whatever parameters they are given.
// The *_DEF constants are those helpers evaluated at the default parameters.
package btle_rx_fe_pkg;

    typedef enum logic {
        FE_IDLE = 1'b0,
        FE_RUN  = 1'b1
    } fe_state_e;

    // Width of a boxcar sum of 2^dlog2 samples of adc_w bits.
    function automatic int sum_width(input int adc_w, input int dlog2);
        return adc_w + dlog2;
    endfunction

    // Left shift that places the boxcar sum at the top of the output word.
    function automatic int out_shift(input int out_w, input int adc_w, input int dlog2);
        return out_w - adc_w - dlog2;
    endfunction

    // DC accumulator width. One bit of headroom above out_w + shift.
    function automatic int dc_acc_width(input int out_w, input int alpha_shift);
        return out_w + alpha_shift + 1;
    endfunction

    // Saturation bounds of a signed w-bit output.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam int     SUM_W_DEF     = sum_width(12, 1);
    localparam int     OUT_SHIFT_DEF = out_shift(16, 12, 1);
    localparam int     DC_ACC_W_DEF  = dc_acc_width(16, 10);
    localparam longint SAT_MAX_DEF   = sat_max(16);
    localparam longint SAT_MIN_DEF   = sat_min(16);

endpackage

// File: rtl/btle_rx_iq_frontend_if.sv
// btle_rx_iq_frontend_if: ADC-side and controller-side signals of the RX frontend.
//   adc_i/adc_q/adc_valid : raw signed ADC samples and their strobe
//   enable                : frontend run; low flushes the current group
//   rx_i/q_signal         : decimated signed samples toward the controller
//   rx_iq_valid           : one-cycle strobe per output pair
//   sat_flag              : sticky saturation indicator
// Modport master drives the ADC side; modport slave is the frontend itself.
interface btle_rx_iq_frontend_if #(
    parameter int ADC_BIT_WIDTH               = 12,
    parameter int GFSK_DEMODULATION_BIT_WIDTH = 16
);
    logic signed [ADC_BIT_WIDTH-1:0]               adc_i;
    logic signed [ADC_BIT_WIDTH-1:0]               adc_q;
    logic                                          adc_valid;
    logic                                          enable;
    logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] rx_i_signal;
    logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] rx_q_signal;
    logic                                          rx_iq_valid;
    logic                                          sat_flag;

    modport master (
        output adc_i, adc_q, adc_valid, enable,
        input  rx_i_signal, rx_q_signal, rx_iq_valid, sat_flag
    );

    modport slave (
        input  adc_i, adc_q, adc_valid, enable,
        output rx_i_signal, rx_q_signal, rx_iq_valid, sat_flag
    );
endinterface

// File: rtl/btle_rx_iq_frontend_dc.sv
// btle_rx_dc_tracker: single-channel DC estimate, subtraction and saturation.
//   clk, rst : clock, asynchronous active-high reset (the only way to clear dc_acc)
//   strobe   : a new decimated sample s is present this cycle
//   s        : scaled decimated sample
//   y        : s minus the current DC estimate, saturated to W bits (combinational)
//   sat      : y was clamped this cycle
// The estimate is dc_acc >>> SHIFT. The output uses the estimate before dc_acc is
// updated, so the frontend latency is unchanged.
module btle_rx_dc_tracker
    import btle_rx_fe_pkg::*;
#(
    parameter int W     = 16,
    parameter int SHIFT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic signed [W-1:0] s,
    output logic signed [W-1:0] y,
    output logic                sat
);
    localparam int DW = dc_acc_width(W, SHIFT);
    localparam logic signed [W+1:0] Y_MAX = (W+2)'(sat_max(W));
    localparam logic signed [W+1:0] Y_MIN = (W+2)'(sat_min(W));

    logic signed [DW-1:0] dc_acc_q;
    logic signed [W:0]    est;   // dc_acc >>> SHIFT always fits in W+1 bits
    logic signed [W+1:0]  diff;

    assign est  = (W+1)'(dc_acc_q >>> SHIFT);
    assign diff = (W+2)'(s) - (W+2)'(est);

    always_comb begin
        sat = 1'b0;
        y   = W'(diff);
        if (diff > Y_MAX) begin
            sat = 1'b1;
            y   = W'(Y_MAX);
        end else if (diff < Y_MIN) begin
            sat = 1'b1;
            y   = W'(Y_MIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dc_acc_q <= '0;
        else if (strobe)
            dc_acc_q <= dc_acc_q + DW'(s) - DW'(est);
    end
endmodule

// File: rtl/btle_rx_iq_frontend.sv
// btle_rx_iq_frontend: boxcar-decimating RX sample conditioner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : btle_rx_iq_frontend_if.slave (ADC input, enable, rx_* outputs, sat_flag)
// Each group of 2^DECIM_LOG2 accepted samples is summed, shifted up to
// GFSK_DEMODULATION_BIT_WIDTH and emitted one clock after the group's last sample.
// Optional macro BTLE_RX_DC_REMOVAL_EN adds a per-channel DC tracker with output
// saturation. Without the macro, output = scaled sum and sat_flag stays 0.
module btle_rx_iq_frontend
    import btle_rx_fe_pkg::*;
#(
    parameter int ADC_BIT_WIDTH               = 12,
    parameter int GFSK_DEMODULATION_BIT_WIDTH = 16,
    parameter int DECIM_LOG2                  = 1,
    parameter int DC_ALPHA_SHIFT              = 10
) (
    input logic                  clk,
    input logic                  rst,
    btle_rx_iq_frontend_if.slave bus
);
    localparam int W     = GFSK_DEMODULATION_BIT_WIDTH;
    localparam int SUM_W = sum_width(ADC_BIT_WIDTH, DECIM_LOG2);
    localparam int SHIFT = out_shift(W, ADC_BIT_WIDTH, DECIM_LOG2);
    // With DECIM_LOG2 = 0 a 1-bit counter is kept at 0, so every sample is a group's last.
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    fe_state_e state_q, state_d;
    logic      take, flush, last, emit, sat_hit;

    logic [CNT_W-1:0]        cnt_q;
    logic signed [SUM_W-1:0] acc_i_q, acc_q_q, sum_i, sum_q;
    logic signed [W-1:0]     s_i, s_q, y_i, y_q;
    logic signed [W-1:0]     rx_i_q, rx_q_q;
    logic                    vld_q, sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FE_IDLE;
        else     state_q <= state_d;
    end

    // enable acts in the same cycle: a sample is never accepted while enable is low.
    // The flush output marks the RUN->IDLE cycle, which clears the sticky flag.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            FE_IDLE: begin
                if (bus.enable) begin
                    state_d = FE_RUN;
                    take    = bus.adc_valid;
                end
            end
            FE_RUN: begin
                if (!bus.enable) begin
                    state_d = FE_IDLE;
                    flush   = 1'b1;
                end else begin
                    take = bus.adc_valid;
                end
            end
            default: state_d = FE_IDLE;
        endcase
    end

    assign last  = (cnt_q == LAST);
    assign emit  = take && last;
    assign sum_i = acc_i_q + SUM_W'(bus.adc_i);
    assign sum_q = acc_q_q + SUM_W'(bus.adc_q);
    assign s_i   = W'(sum_i) <<< SHIFT;
    assign s_q   = W'(sum_q) <<< SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (!bus.enable) begin
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else if (bus.adc_valid) begin
            if (last) begin
                cnt_q   <= '0;
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
            end
        end
    end

`ifdef BTLE_RX_DC_REMOVAL_EN
    logic sat_i, sat_q_ch;

    btle_rx_dc_tracker #(.W(W), .SHIFT(DC_ALPHA_SHIFT)) u_dc_i (
        .clk(clk), .rst(rst), .strobe(emit), .s(s_i), .y(y_i), .sat(sat_i)
    );
    btle_rx_dc_tracker #(.W(W), .SHIFT(DC_ALPHA_SHIFT)) u_dc_q (
        .clk(clk), .rst(rst), .strobe(emit), .s(s_q), .y(y_q), .sat(sat_q_ch)
    );

    assign sat_hit = emit && (sat_i || sat_q_ch);
`else
    assign y_i     = s_i;
    assign y_q     = s_q;
    assign sat_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_i_q <= '0;
            rx_q_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= emit;
            if (emit) begin
                rx_i_q <= y_i;
                rx_q_q <= y_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          sat_q <= 1'b0;
        else if (flush)   sat_q <= 1'b0;
        else if (sat_hit) sat_q <= 1'b1;
    end

    assign bus.rx_i_signal = rx_i_q;
    assign bus.rx_q_signal = rx_q_q;
    assign bus.rx_iq_valid = vld_q;
    assign bus.sat_flag    = sat_q;
endmodule

// File: tb/tb_btle_rx_iq_frontend.sv
// Testbench for btle_rx_iq_frontend. A sample-queue model predicts every output
// pair (sum of the group, scaled, optional DC subtraction) and a negedge process
// compares the DUT against it each cycle. Directed literal checks pin the model.
// Honours BTLE_RX_DC_REMOVAL_EN the same way the RTL does.
module tb_btle_rx_iq_frontend;
    localparam int A     = 12;
    localparam int W     = 16;
    localparam int D     = 1;
    localparam int SH    = 10;
    localparam int N     = 1 << D;
    localparam int SHIFT = W - A - D;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btle_rx_iq_frontend_if #(.ADC_BIT_WIDTH(A), .GFSK_DEMODULATION_BIT_WIDTH(W)) bus ();

    btle_rx_iq_frontend #(
        .ADC_BIT_WIDTH(A), .GFSK_DEMODULATION_BIT_WIDTH(W),
        .DECIM_LOG2(D), .DC_ALPHA_SHIFT(SH)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int     grp_i[$];
    int     grp_q[$];
    longint dc_i, dc_q;
    int     exp_i, exp_q;
    bit     exp_v, exp_sat, prev_en;

    task automatic dc_step(input int s, inout longint dc, output int y, output bit hit);
        longint est;
        longint d;
        est = dc >>> SH;
        d   = longint'(s) - est;
        hit = 1'b0;
        if (d > MAXV) begin d = MAXV; hit = 1'b1; end
        else if (d < MINV) begin d = MINV; hit = 1'b1; end
        y  = int'(d);
        dc = dc + longint'(s) - est;
    endtask

    always @(posedge clk or posedge rst) begin : model
        int si, sq, yi, yq;
        bit hi, hq;
        if (rst) begin
            grp_i.delete(); grp_q.delete();
            exp_v = 0; exp_i = 0; exp_q = 0; exp_sat = 0;
            dc_i = 0; dc_q = 0; prev_en = 0;
        end else begin
            exp_v = 0;
            if (bus.enable) begin
                if (bus.adc_valid) begin
                    grp_i.push_back(int'(bus.adc_i));
                    grp_q.push_back(int'(bus.adc_q));
                    if (grp_i.size() == N) begin
                        si = 0; sq = 0;
                        foreach (grp_i[k]) begin
                            si += grp_i[k];
                            sq += grp_q[k];
                        end
                        si = si * (1 << SHIFT);
                        sq = sq * (1 << SHIFT);
`ifdef BTLE_RX_DC_REMOVAL_EN
                        dc_step(si, dc_i, yi, hi);
                        dc_step(sq, dc_q, yq, hq);
                        if (hi || hq) exp_sat = 1;
`else
                        yi = si; yq = sq; hi = 0; hq = 0;
`endif
                        exp_i = yi; exp_q = yq; exp_v = 1;
                        grp_i.delete(); grp_q.delete();
                    end
                end
            end else begin
                grp_i.delete(); grp_q.delete();
                if (prev_en) exp_sat = 0;
            end
            prev_en = bus.enable;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", int'(bus.rx_iq_valid), int'(exp_v));
            chk("rx_i", int'(bus.rx_i_signal), exp_i);
            chk("rx_q", int'(bus.rx_q_signal), exp_q);
            chk("sat", int'(bus.sat_flag), int'(exp_sat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int i, input int q, input bit v, input bit en);
        bus.adc_i     = i[A-1:0];
        bus.adc_q     = q[A-1:0];
        bus.adc_valid = v;
        bus.enable    = en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vpos[$];
        int r;
        rst = 1'b1;
        bus.adc_i = '0; bus.adc_q = '0; bus.adc_valid = 1'b0; bus.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rx_i", int'(bus.rx_i_signal), 0);
        chk("reset_rx_q", int'(bus.rx_q_signal), 0);
        chk("reset_valid", int'(bus.rx_iq_valid), 0);
        chk("reset_sat", int'(bus.sat_flag), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0);

        // Constant I=100, Q=-50; the first group after reset is unaffected by DC.
        drive(100, -50, 1, 1);
        chk("t1_first_novalid", int'(bus.rx_iq_valid), 0);
        drive(100, -50, 1, 1);
        chk("t1_valid", int'(bus.rx_iq_valid), 1);
        chk("t1_rx_i", int'(bus.rx_i_signal), 1600);
        chk("t1_rx_q", int'(bus.rx_q_signal), -800);
        for (int k = 0; k < 4; k++) begin
            drive(100, -50, 1, 1);
            chk("t1_cadence", int'(bus.rx_iq_valid), k % 2);
        end

        // Full-scale groups.
        drive(2047, 0, 1, 1);
        drive(2047, 0, 1, 1);
`ifndef BTLE_RX_DC_REMOVAL_EN
        chk("t2_max", int'(bus.rx_i_signal), 32752);
        chk("t2_max_sat", int'(bus.sat_flag), 0);
`endif
        drive(-2048, 0, 1, 1);
        drive(-2048, 0, 1, 1);
`ifndef BTLE_RX_DC_REMOVAL_EN
        chk("t2_min", int'(bus.rx_i_signal), -32768);
`endif

        // enable dropped mid-group: partial group discarded.
        drive(5, 5, 1, 1);
        drive(0, 0, 0, 0);
        chk("t3_drop_novalid", int'(bus.rx_iq_valid), 0);
        drive(9, 9, 1, 0);
        chk("t3_idle_novalid", int'(bus.rx_iq_valid), 0);
        drive(10, 1, 1, 1);
        chk("t3_restart_novalid", int'(bus.rx_iq_valid), 0);
        drive(20, 2, 1, 1);
        chk("t3_restart_valid", int'(bus.rx_iq_valid), 1);
`ifndef BTLE_RX_DC_REMOVAL_EN
        chk("t3_rx_i", int'(bus.rx_i_signal), 240);
        chk("t3_rx_q", int'(bus.rx_q_signal), 24);
`endif

        // adc_valid every third cycle: one output every 6 clocks.
        for (int k = 0; k < 12; k++) begin
            drive(k * 7, -k * 3, (k % 3) == 0, 1);
            if (bus.rx_iq_valid) vpos.push_back(k);
        end
        chk("t4_count", vpos.size(), 2);
        if (vpos.size() == 2) chk("t4_period", vpos[1] - vpos[0], 6);

        // Asynchronous reset mid-group.
        drive(300, 30, 1, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_rx_i", int'(bus.rx_i_signal), 0);
        chk("t5_rst_rx_q", int'(bus.rx_q_signal), 0);
        chk("t5_rst_valid", int'(bus.rx_iq_valid), 0);
        rst = 1'b0;
        drive(7, 3, 1, 1);
        chk("t5_after_novalid", int'(bus.rx_iq_valid), 0);
        drive(9, 5, 1, 1);
        chk("t5_after_valid", int'(bus.rx_iq_valid), 1);
        chk("t5_after_rx_i", int'(bus.rx_i_signal), 128);
        chk("t5_after_rx_q", int'(bus.rx_q_signal), 64);

        // Randomized traffic: random samples, duty cycle and enable drops.
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            drive($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048,
                  $urandom_range(0, 2) != 0, r >= 3);
        end

`ifdef BTLE_RX_DC_REMOVAL_EN
        // DC convergence from a cleared estimate.
        drive(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        for (int k = 0; k < 20000; k++) drive(100, -50, 1, 1);
        chk("dc_converged_i", int'(bus.rx_i_signal >= -2 && bus.rx_i_signal <= 2), 1);
        chk("dc_converged_q", int'(bus.rx_q_signal >= -2 && bus.rx_q_signal <= 2), 1);
        drive(2047, -50, 1, 1);
        drive(2047, -50, 1, 1);
        chk("dc_step_range", int'(bus.rx_i_signal >= 31150 && bus.rx_i_signal <= 31153), 1);
        chk("dc_step_nosat", int'(bus.sat_flag), 0);
        // Pull the estimate strongly negative, clear the flag, then step up.
        for (int k = 0; k < 4000; k++) drive(-2048, -50, 1, 1);
        drive(0, 0, 0, 0);
        chk("dc_sat_cleared", int'(bus.sat_flag), 0);
        drive(2047, -50, 1, 1);
        drive(2047, -50, 1, 1);
        chk("dc_sat_clamp", int'(bus.rx_i_signal), 32767);
        chk("dc_sat_set", int'(bus.sat_flag), 1);
        for (int k = 0; k < 8; k++) drive(0, -50, 1, 1);
        chk("dc_sat_sticky", int'(bus.sat_flag), 1);
        drive(0, 0, 0, 0);
        chk("dc_sat_enable_clear", int'(bus.sat_flag), 0);
`endif

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
